door_timer_display: RTL and testbench

- Parametrised multi-digit BCD second timer with built-in multiplexed 7-segment drive, for elevator door-hold and arrival timing.
- Counts up or down once per second-tick while enabled. It can be loaded or cleared, and pulses a terminal event.
- It scans its digits onto one shared segment bus.
- Sits between the elevator control FSM (run/load/dir/clr, done) and the board's seven-segment digits.

---
 rtl/door_timer_pkg.sv | 49 ++++
 rtl/door_timer_display_bcd_to_seg7.sv | 25 ++
 rtl/door_timer_display.sv | 133 +++++++++++++
 tb/tb_door_timer_display.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/door_timer_pkg.sv
// Shared constants and the per-digit BCD step helper for the door timer.
package door_timer_pkg;

  localparam int DIGIT_W = 4;

  // Segment order is {a,b,c,d,e,f,g}, active-high.
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Returns {carry/borrow out, new digit}; a digit with no carry in is passed through.
  function automatic logic [DIGIT_W:0] bcd_digit_step(input logic [DIGIT_W-1:0] digit,
                                                      input logic down,
                                                      input logic cin);
    logic [DIGIT_W-1:0] d;
    logic               cout;
    d    = digit;
    cout = 1'b0;
    if (cin) begin
      if (down) begin
        if (digit == 4'd0) begin
          d    = 4'd9;
          cout = 1'b1;
        end else begin
          d = digit - 4'd1;
        end
      end else if (digit >= 4'd9) begin
        d    = 4'd0;
        cout = 1'b1;
      end else begin
        d = digit + 4'd1;
      end
    end
    return {cout, d};
  endfunction

  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] digit);
    return (digit > 4'd9) ? 4'd9 : digit;
  endfunction

endpackage

// File: rtl/door_timer_display_bcd_to_seg7.sv
// Combinational BCD digit to 7-segment pattern decoder; non-BCD codes go dark.
module bcd_to_seg7
  import door_timer_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [6:0]         seg
);

  always_comb begin
    unique case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/door_timer_display.sv
// BCD second timer (up/down, load/clear, terminal pulse) with a scanned 7-segment drive.
module door_timer_display
  import door_timer_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 50000000,
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      dir,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_val,
  input  logic                      clr,
  output logic [DIGIT_W*DIGITS-1:0] count,
  output logic                      done,
  output logic [DIGITS-1:0]         sm_bit,
  output logic [6:0]                sm_seg
);

  localparam int CW     = DIGIT_W * DIGITS;
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [TICK_W-1:0] presc;
  logic [CW-1:0]     count_step;
  logic [CW-1:0]     load_clamped;
  logic              step_event;
  logic              carry;

  logic [SCAN_W-1:0] scan_cnt;
  logic [IDX_W-1:0]  scan_idx;
  logic [DIGITS-1:0] lz_mask;
  logic              all_zero;
  logic [DIGIT_W-1:0] sel_digit;
  logic [6:0]        sel_seg;
  logic [DIGITS-1:0] sm_bit_d;
  logic [6:0]        sm_seg_d;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    count_step = count;
    step_event = 1'b0;
    carry      = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      {carry, count_step[i*DIGIT_W +: DIGIT_W]} =
        bcd_digit_step(count[i*DIGIT_W +: DIGIT_W], dir, carry);
    end
    if (dir) begin
      // Down-counting saturates at zero instead of borrowing round to all-9s.
      if (count == '0) count_step = '0;
      step_event = (count != '0) && (count_step == '0);
    end else begin
      step_event = carry;
    end
  end

  always_comb begin
    load_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_clamped[i*DIGIT_W +: DIGIT_W] = clamp_digit(load_val[i*DIGIT_W +: DIGIT_W]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      presc <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        count <= '0;
        presc <= '0;
      end else if (load) begin
        count <= load_clamped;
        presc <= '0;
      end else if (!run) begin
        presc <= '0;
      end else if (presc == TICK_W'(TICK_DIV - 1)) begin
        presc <= '0;
        count <= count_step;
        done  <= step_event;
      end else begin
        presc <= presc + TICK_W'(1);
      end
    end
  end

  // Leading-zero mask: digit i>0 is dark when it and every higher digit are zero.
  always_comb begin
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero   = all_zero && (count[i*DIGIT_W +: DIGIT_W] == 4'd0);
      lz_mask[i] = BLANK_LZ && all_zero && (i != 0);
    end
  end

  always_comb begin
    sel_digit = count[int'(scan_idx)*DIGIT_W +: DIGIT_W];
    sm_bit_d  = DIGITS'(1) << scan_idx;
    sm_seg_d  = lz_mask[scan_idx] ? SEG_BLANK : sel_seg;
  end

  bcd_to_seg7 u_seg (
    .digit (sel_digit),
    .seg   (sel_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      sm_bit   <= DIGITS'(1);
      sm_seg   <= SEG_0;
    end else begin
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      sm_bit <= sm_bit_d;
      sm_seg <= sm_seg_d;
    end
  end

endmodule

// File: tb/tb_door_timer_display.sv
// Directed bench for door_timer_display with DIGITS=2, TICK_DIV=4, SCAN_DIV=2.
module tb_door_timer_display;

  localparam int DIGITS   = 2;
  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] load_val = 8'h00;

  logic [7:0] count, count_nb;
  logic       done, done_nb;
  logic [1:0] sm_bit, sm_bit_nb;
  logic [6:0] sm_seg, sm_seg_nb;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  door_timer_display #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .run(run), .dir(dir), .load(load), .load_val(load_val), .clr(clr),
    .count(count), .done(done), .sm_bit(sm_bit), .sm_seg(sm_seg)
  );

  door_timer_display #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .run(run), .dir(dir), .load(load), .load_val(load_val), .clr(clr),
    .count(count_nb), .done(done_nb), .sm_bit(sm_bit_nb), .sm_seg(sm_seg_nb)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    load     = 1'b1;
    load_val = v;
    tick(1);
    load     = 1'b0;
  endtask

  task automatic test_reset;
    run = 1'b1;
    dir = 1'b0;
    rst = 1'b1;
    tick(2);
    checks++; if (count !== 8'h00) begin fails++; $display("FAIL reset_count: got %h expected 00", count); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (sm_bit !== 2'b01) begin fails++; $display("FAIL reset_sm_bit: got %b expected 01", sm_bit); end
    checks++; if (sm_seg !== 7'b1111110) begin fails++; $display("FAIL reset_sm_seg: got %b expected 1111110", sm_seg); end
    rst = 1'b0;
    tick(3);
    checks++; if (count !== 8'h00) begin fails++; $display("FAIL reset_no_early_step: got %h expected 00", count); end
    tick(1);
    checks++; if (count !== 8'h01) begin fails++; $display("FAIL reset_first_step: got %h expected 01", count); end
  endtask

  task automatic test_up_count;
    dir = 1'b0;
    run = 1'b1;
    do_load(8'h08);
    tick(3);
    checks++; if (count !== 8'h08) begin fails++; $display("FAIL up_hold_08: got %h expected 08", count); end
    tick(1);
    checks++; if (count !== 8'h09) begin fails++; $display("FAIL up_09: got %h expected 09", count); end
    tick(4);
    checks++; if (count !== 8'h10) begin fails++; $display("FAIL up_carry_10: got %h expected 10", count); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL up_carry_done: got %b expected 0", done); end
    do_load(8'h99);
    tick(3);
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL up_pre_wrap_done: got %b expected 0", done); end
    tick(1);
    checks++; if (count !== 8'h00) begin fails++; $display("FAIL up_wrap_count: got %h expected 00", count); end
    checks++; if (done !== 1'b1) begin fails++; $display("FAIL up_wrap_done: got %b expected 1", done); end
    tick(1);
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL up_wrap_done_width: got %b expected 0", done); end
  endtask

  task automatic test_down_count;
    logic [7:0] exp_cnt;
    logic       exp_done;
    dir = 1'b1;
    run = 1'b1;
    do_load(8'h12);
    for (int k = 1; k <= 12; k++) begin
      for (int c = 0; c < 4; c++) begin
        tick(1);
        exp_done = (k == 12) && (c == 3);
        checks++; if (done !== exp_done) begin fails++; $display("FAIL down_done step %0d cyc %0d: got %b expected %b", k, c, done, exp_done); end
      end
      exp_cnt = {4'((12 - k) / 10), 4'((12 - k) % 10)};
      checks++; if (count !== exp_cnt) begin fails++; $display("FAIL down_count step %0d: got %h expected %h", k, count, exp_cnt); end
    end
    for (int c = 0; c < 20; c++) begin
      tick(1);
      checks++; if (count !== 8'h00 || done !== 1'b0) begin fails++; $display("FAIL down_saturate cyc %0d: got %h/%b expected 00/0", c, count, done); end
    end
  endtask

  task automatic test_run_pause;
    dir = 1'b0;
    run = 1'b1;
    do_load(8'h40);
    tick(2);
    run = 1'b0;
    tick(5);
    checks++; if (count !== 8'h40) begin fails++; $display("FAIL pause_hold: got %h expected 40", count); end
    run = 1'b1;
    tick(3);
    checks++; if (count !== 8'h40) begin fails++; $display("FAIL pause_restart_early: got %h expected 40", count); end
    tick(1);
    checks++; if (count !== 8'h41) begin fails++; $display("FAIL pause_restart_step: got %h expected 41", count); end
  endtask

  task automatic test_load_clr;
    run = 1'b0;
    dir = 1'b0;
    do_load(8'hA3);
    checks++; if (count !== 8'h93) begin fails++; $display("FAIL load_clamp_hi: got %h expected 93", count); end
    do_load(8'hAF);
    checks++; if (count !== 8'h99) begin fails++; $display("FAIL load_clamp_both: got %h expected 99", count); end
    clr = 1'b1;
    load = 1'b1;
    load_val = 8'h55;
    tick(1);
    clr = 1'b0;
    load = 1'b0;
    checks++; if (count !== 8'h00) begin fails++; $display("FAIL clr_over_load: got %h expected 00", count); end
    dir = 1'b1;
    do_load(8'h05);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    checks++; if (count !== 8'h00 || done !== 1'b0) begin fails++; $display("FAIL clr_no_done: got %h/%b expected 00/0", count, done); end
    do_load(8'h01);
    do_load(8'h00);
    checks++; if (count !== 8'h00 || done !== 1'b0) begin fails++; $display("FAIL load_zero_no_done: got %h/%b expected 00/0", count, done); end
    dir = 1'b0;
    run = 1'b1;
    do_load(8'h50);
    tick(3);
    load = 1'b1;
    load_val = 8'h25;
    tick(1);
    load = 1'b0;
    checks++; if (count !== 8'h25 || done !== 1'b0) begin fails++; $display("FAIL load_over_step: got %h/%b expected 25/0", count, done); end
    tick(3);
    checks++; if (count !== 8'h25) begin fails++; $display("FAIL load_step_restart_early: got %h expected 25", count); end
    tick(1);
    checks++; if (count !== 8'h26) begin fails++; $display("FAIL load_step_restart: got %h expected 26", count); end
  endtask

  task automatic test_display(input logic [7:0] v, input logic [6:0] seg0,
                              input logic [6:0] seg1_lz, input logic [6:0] seg1_nb);
    logic [1:0] prev, v0, exp_bit;
    logic [6:0] exp_lz, exp_nb;
    bit         found;
    run = 1'b0;
    do_load(v);
    tick(2);
    prev  = sm_bit;
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      tick(1);
      if (sm_bit !== prev) found = 1'b1;
    end
    checks++;
    if (!found) begin
      fails++;
      $display("FAIL disp_scan_%h: sm_bit stuck at %b, expected a change within 4 cycles", v, sm_bit);
    end else begin
      v0 = sm_bit;
      checks++; if (v0 !== 2'b01 && v0 !== 2'b10) begin fails++; $display("FAIL disp_onehot_%h: got %b expected 01 or 10", v, v0); end
      for (int k = 0; k < 8; k++) begin
        if (k > 0) tick(1);
        exp_bit = ((k / 2) % 2 == 0) ? v0 : ~v0;
        exp_lz  = (exp_bit == 2'b01) ? seg0 : seg1_lz;
        exp_nb  = (exp_bit == 2'b01) ? seg0 : seg1_nb;
        checks++; if (sm_bit !== exp_bit) begin fails++; $display("FAIL disp_bit_%h k%0d: got %b expected %b", v, k, sm_bit, exp_bit); end
        checks++; if (sm_seg !== exp_lz) begin fails++; $display("FAIL disp_seg_lz_%h k%0d: got %b expected %b", v, k, sm_seg, exp_lz); end
        checks++; if (sm_seg_nb !== exp_nb) begin fails++; $display("FAIL disp_seg_nb_%h k%0d: got %b expected %b", v, k, sm_seg_nb, exp_nb); end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_up_count();
    test_down_count();
    test_run_pause();
    test_load_clr();
    test_display(8'h07, 7'b1110000, 7'b0000000, 7'b1111110);
    test_display(8'h30, 7'b1111110, 7'b1111001, 7'b1111001);
    test_display(8'h00, 7'b1111110, 7'b0000000, 7'b1111110);
    test_display(8'h58, 7'b1111111, 7'b1011011, 7'b1011011);
    checks++; if (count_nb !== count || done_nb !== done) begin fails++; $display("FAIL nb_count_agree: got %h/%b expected %h/%b", count_nb, done_nb, count, done); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
